avst_pkt_arbiter: RTL

Packet-granular round-robin arbiter that shares one Avalon-ST byte-stream consumer (the packet-sum adder) among N_REQ requester streams. It grants one requester and holds the grant until that packet's end beat is accepted, so packets never interleave. The granted channel id travels alongside the packet on `out_chan` so downstream logic can tag the result. It sits between the requester sources and the adder's sink port.

---
 rtl/avst_pkt_arbiter_pkg.sv | 12 +
 rtl/avst_pkt_arbiter_rr_pick.sv | 34 +++
 rtl/avst_pkt_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/avst_pkt_arbiter_pkg.sv
// Shared definitions for the Avalon-ST packet arbiter slice:
// arbiter FSM states and the default beat width.
package avst_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int BEAT_DATA_W = 8;

endpackage

// File: rtl/avst_pkt_arbiter_rr_pick.sv
// Combinational round-robin priority selector: returns the first set request
// found when searching from ptr upward, wrapping at N_REQ.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int CH_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [CH_W-1:0]  ptr,
   output logic [CH_W-1:0]  gnt_id,
   output logic             any
);

   localparam logic [CH_W:0] N_W = (CH_W+1)'(N_REQ);

   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]   rot;
   logic [CH_W-1:0]    off;
   logic [CH_W:0]      sum;

   // Rotate the doubled request vector so bit 0 is the pointer position,
   // then take the lowest set bit as the offset from the pointer.
   always_comb begin
      dbl = {req, req} >> ptr;
      rot = dbl[N_REQ-1:0];
      off = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         off = rot[k] ? CH_W'(k) : off;
      end
      sum    = {1'b0, ptr} + {1'b0, off};
      gnt_id = (sum >= N_W) ? CH_W'(sum - N_W) : sum[CH_W-1:0];
      any    = |req;
   end

endmodule

// File: rtl/avst_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing one Avalon-ST consumer among
// N_REQ requesters; the grant is held until the packet's end beat is accepted.
module avst_pkt_arbiter
   import avst_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = BEAT_DATA_W,
   parameter int CH_W   = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ*DATA_W-1:0] in_data,
   input  logic [N_REQ-1:0]        in_end,
   input  logic [N_REQ-1:0]        in_valid,
   output logic [N_REQ-1:0]        in_ready,
   input  logic [N_REQ-1:0]        chan_en,
   output logic [DATA_W-1:0]       out_data,
   output logic                    out_end,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CH_W-1:0]         out_chan,
   output logic                    busy,
   output logic                    pkt_done
);

   localparam logic [CH_W-1:0] LAST_ID = CH_W'(N_REQ - 1);

   arb_state_e       state_q, state_d;
   logic [CH_W-1:0]  gnt_q, gnt_d;
   logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic             pkt_done_q, pkt_done_d;

   logic [N_REQ-1:0] req;
   logic [CH_W-1:0]  pick_id;
   logic             pick_any;
   logic             xfer_end;

   assign req = in_valid & chan_en;

   rr_pick #(
      .N_REQ (N_REQ),
      .CH_W  (CH_W)
   ) u_rr_pick (
      .req    (req),
      .ptr    (rr_ptr_q),
      .gnt_id (pick_id),
      .any    (pick_any)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         rr_ptr_q   <= '0;
         pkt_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         rr_ptr_q   <= rr_ptr_d;
         pkt_done_q <= pkt_done_d;
      end
   end

   // Next-state logic; chan_en only matters while choosing in IDLE
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      rr_ptr_d   = rr_ptr_q;
      pkt_done_d = 1'b0;
      xfer_end   = in_valid[gnt_q] && in_end[gnt_q] && out_ready;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = GRANT;
               gnt_d   = pick_id;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            if (xfer_end) begin
               state_d    = IDLE;
               pkt_done_d = 1'b1;
               rr_ptr_d   = (gnt_q == LAST_ID) ? '0 : gnt_q + 1'b1;
            end else begin
               state_d = GRANT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: zero-latency pass-through of the granted channel
   always_comb begin
      in_ready  = '0;
      out_data  = '0;
      out_end   = 1'b0;
      out_valid = 1'b0;
      out_chan  = '0;
      busy      = 1'b0;
      case (state_q)
         GRANT: begin
            out_data        = in_data[int'(gnt_q)*DATA_W +: DATA_W];
            out_end         = in_end[gnt_q];
            out_valid       = in_valid[gnt_q];
            in_ready[gnt_q] = out_ready;
            out_chan        = gnt_q;
            busy            = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign pkt_done = pkt_done_q;

endmodule
